// File: rtl/stream_conv3x3.sv
// rtl/stream_conv3x3.sv - 3x3 streaming pixel processor with backpressure; CONV_ROUND_EN enables conv rounding
module stream_conv3x3 #(
   parameter int DW    = 8,
   parameter int IMG_W = 32,
   parameter int IMG_H = 32,
   parameter int KW    = 8,
   parameter int SHIFT = 3
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [DW-1:0]   s_data,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [1:0]      mode,
   input  logic [9*KW-1:0] kernel,
   input  logic [DW-1:0]   thresh,
   output logic [DW-1:0]   m_data,
   output logic            m_valid,
   input  logic            m_ready,
   output logic            frame_done,
   output logic            busy
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int SW = DW + KW + 5;
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
   localparam logic signed [SW-1:0] MAX_S = SW'((64'(1) << DW) - 1);
`ifdef CONV_ROUND_EN
   localparam logic signed [SW-1:0] RND = SW'((64'(1) << SHIFT) >> 1);
`endif

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'b00,
      MODE_INVERT = 2'b01,
      MODE_CONV   = 2'b10,
      MODE_THRESH = 2'b11
   } mode_e;

   logic adv, accept, xfer, at_origin, at_last;
   mode_e eff_mode;

   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   mode_e           mode_q, mode_d;
   logic [9*KW-1:0] kernel_q, kernel_d;
   logic [DW-1:0]   thresh_q, thresh_d;

   logic [DW-1:0] win_q [3][3];
   logic [DW-1:0] win_d [3][3];
   logic          s1_valid_q, s1_valid_d;
   logic          s1_last_q, s1_last_d;

   logic [DW-1:0] m_data_q, m_data_d;
   logic          m_valid_q, m_valid_d;
   logic          m_last_q, m_last_d;
   logic          busy_q, busy_d;

   logic [DW-1:0] lb0_mem [IMG_W];
   logic [DW-1:0] lb1_mem [IMG_W];
   logic [DW-1:0] lb0_rd, lb1_rd;

   logic signed [SW-1:0] sum, pe, ce, shifted;
   logic [DW-1:0] conv_res, res;

   // Handshake: every stage moves together whenever the output register can take data
   assign adv        = !m_valid_q || m_ready;
   assign s_ready    = adv;
   assign accept     = s_valid && adv;
   assign xfer       = m_valid_q && m_ready;
   assign at_origin  = (col_q == '0) && (row_q == '0);
   assign at_last    = (col_q == LAST_COL) && (row_q == LAST_ROW);
   assign eff_mode   = at_origin ? mode_e'(mode) : mode_q;
   assign lb0_rd     = lb0_mem[col_q];
   assign lb1_rd     = lb1_mem[col_q];
   assign m_data     = m_data_q;
   assign m_valid    = m_valid_q;
   assign frame_done = xfer && m_last_q;
   assign busy       = busy_q && !frame_done;

   // Raster position tracking and frame-start latching of configuration
   always_comb begin
      col_d    = col_q;
      row_d    = row_q;
      mode_d   = mode_q;
      kernel_d = kernel_q;
      thresh_d = thresh_q;
      if (accept) begin
         if (at_origin) begin
            mode_d   = mode_e'(mode);
            kernel_d = kernel;
            thresh_d = thresh;
         end
         if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Stage 1: window shift on accept; conv bubbles for pixels without a full neighbourhood
   always_comb begin
      win_d      = win_q;
      s1_valid_d = s1_valid_q;
      s1_last_d  = s1_last_q;
      if (adv) begin
         s1_valid_d = accept && ((eff_mode != MODE_CONV) ||
                                 ((row_q >= RW'(2)) && (col_q >= CW'(2))));
         s1_last_d  = accept && at_last;
         if (accept) begin
            for (int r = 0; r < 3; r++) begin
               win_d[r][0] = win_q[r][1];
               win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb0_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = s_data;
         end
      end
   end

   // Signed 3x3 multiply-accumulate, shift normalisation and clamp to pixel range
   always_comb begin
      sum = '0;
      pe  = '0;
      ce  = '0;
      for (int wr = 0; wr < 3; wr++) begin
         for (int wc = 0; wc < 3; wc++) begin
            pe  = {{(SW-DW){1'b0}}, win_q[wr][wc]};
            ce  = {{(SW-KW){kernel_q[(3*wr+wc)*KW + KW-1]}}, kernel_q[(3*wr+wc)*KW +: KW]};
            sum = sum + pe * ce;
         end
      end
`ifdef CONV_ROUND_EN
      sum = sum + RND;
`endif
      shifted = sum >>> SHIFT;
      if (shifted < 0) begin
         conv_res = '0;
      end else if (shifted > MAX_S) begin
         conv_res = '1;
      end else begin
         conv_res = shifted[DW-1:0];
      end
   end

   // Per-mode result for the pixel held in stage 1 (newest pixel sits at window centre-right bottom)
   always_comb begin
      res = win_q[2][2];
      case (mode_q)
         MODE_BYPASS: res = win_q[2][2];
         MODE_INVERT: res = {DW{1'b1}} - win_q[2][2];
         MODE_CONV:   res = conv_res;
         MODE_THRESH: res = (win_q[2][2] >= thresh_q) ? {DW{1'b1}} : '0;
         default:     res = win_q[2][2];
      endcase
   end

   // Stage 2 output register and frame busy tracking
   always_comb begin
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      busy_d    = busy_q;
      if (adv) begin
         m_valid_d = s1_valid_q;
         m_last_d  = s1_last_q;
         if (s1_valid_q) begin
            m_data_d = res;
         end
      end
      if (frame_done) begin
         busy_d = 1'b0;
      end
      if (accept) begin
         busy_d = 1'b1;
      end
   end

   // Line buffers: deliberately not reset, only complete neighbourhoods are ever consumed
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1_mem[col_q] <= s_data;
         lb0_mem[col_q] <= lb1_rd;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col_q      <= '0;
         row_q      <= '0;
         mode_q     <= MODE_BYPASS;
         kernel_q   <= '0;
         thresh_q   <= '0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_q[r][c] <= '0;
            end
         end
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         mode_q     <= mode_d;
         kernel_q   <= kernel_d;
         thresh_q   <= thresh_d;
         win_q      <= win_d;
         s1_valid_q <= s1_valid_d;
         s1_last_q  <= s1_last_d;
         m_data_q   <= m_data_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         busy_q     <= busy_d;
      end
   end

endmodule

// File: tb/tb_stream_conv3x3.sv
// tb/tb_stream_conv3x3.sv - scoreboard bench for stream_conv3x3 (4x4 frames)
module tb_stream_conv3x3;

   localparam int W = 4;
   localparam int H = 4;
   localparam int SH = 3;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic [1:0]  mode;
   logic [71:0] kernel;
   logic [7:0]  thresh;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        frame_done;
   logic        busy;

   stream_conv3x3 #(.DW(8), .IMG_W(W), .IMG_H(H), .KW(8), .SHIFT(SH)) dut (
      .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .mode(mode), .kernel(kernel), .thresh(thresh), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       last;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   int img[H][W];
   int mrow = 0, mcol = 0;
   int lmode = 0, lth = 0;
   int lk[9];
   int kc[9];

   bit   acc, xfer;
   int   hold = 0;
   bit   stall_chk = 0, have_prev = 0;
   logic [7:0] prev_d;
   int   cyc = 0, first_acc = -1, first_val = -1, n_fd = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int conv_ref(input int r, input int c);
      int sum = 0;
      int res;
      for (int wr = 0; wr < 3; wr++)
         for (int wc = 0; wc < 3; wc++)
            sum += img[r-2+wr][c-2+wc] * lk[3*wr+wc];
`ifdef CONV_ROUND_EN
      sum += (1 << SH) >> 1;
`endif
      res = sum >>> SH;
      if (res < 0) res = 0;
      if (res > 255) res = 255;
      return res;
   endfunction

   task automatic model_accept(input logic [7:0] d);
      exp_t e;
      bit   push = 1;
      if (mrow == 0 && mcol == 0) begin
         lmode = int'(mode);
         lth   = int'(thresh);
         for (int k = 0; k < 9; k++) lk[k] = kc[k];
      end
      img[mrow][mcol] = int'(d);
      e.last = (mrow == H-1) && (mcol == W-1);
      case (lmode)
         0: e.d = d;
         1: e.d = 8'hFF - d;
         3: e.d = (int'(d) >= lth) ? 8'hFF : 8'h00;
         default: begin
            push = (mrow >= 2) && (mcol >= 2);
            e.d  = 8'(conv_ref(mrow, mcol));
         end
      endcase
      if (push) sb.push_back(e);
      if (mcol == W-1) begin
         mcol = 0;
         mrow = (mrow == H-1) ? 0 : mrow + 1;
      end else begin
         mcol++;
      end
   endtask

   task automatic set_kernel();
      for (int k = 0; k < 9; k++) kernel[k*8 +: 8] = 8'(kc[k]);
   endtask

   task automatic step(input logic sv, input logic [7:0] sd);
      exp_t e;
      @(negedge clk);
      s_valid = sv;
      s_data  = sd;
      m_ready = (hold == 0);
      if (hold > 0) hold--;
      #1;
      acc  = s_valid && s_ready;
      xfer = m_valid && m_ready;
      if (!m_ready && stall_chk) begin
         chk("s_ready_stall", s_ready, 0);
         if (have_prev) chk("m_data_hold", m_data, prev_d);
         prev_d = m_data;
         have_prev = 1;
      end else begin
         have_prev = 0;
      end
      if (m_valid && first_val < 0) first_val = cyc;
      if (xfer) begin
         if (sb.size() == 0) begin
            chk("spurious_output", m_data, 32'hDEAD);
         end else begin
            e = sb.pop_front();
            chk("data", m_data, e.d);
            chk("frame_done", frame_done, e.last);
            if (frame_done) n_fd++;
         end
      end else begin
         chk("frame_done_idle", frame_done, 0);
      end
      if (acc) begin
         if (first_acc < 0) first_acc = cyc;
         model_accept(sd);
      end
      cyc++;
   endtask

   task automatic send_pixel(input logic [7:0] d);
      int tries = 0;
      do begin
         step(1'b1, d);
         tries++;
      end while (!acc && tries < 100);
      if (!acc) chk("accept_timeout", 0, 1);
   endtask

   // kind 0: ramp 0..15, kind 1: constant v, kind 2: alternating 0x7F/0x80
   task automatic send_frame(input int kind, input int v);
      for (int i = 0; i < W*H; i++) begin
         case (kind)
            0: send_pixel(8'(i));
            1: send_pixel(8'(v));
            default: send_pixel((i % 2) ? 8'h80 : 8'h7F);
         endcase
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         step(1'b0, 8'h00);
         n++;
      end
      step(1'b0, 8'h00);
      chk("drain_empty", sb.size(), 0);
   endtask

   task automatic centre_only(input int c);
      for (int k = 0; k < 9; k++) kc[k] = 0;
      kc[4] = c;
      set_kernel();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      mode = 2'b00; thresh = '0; kernel = '0;
      for (int k = 0; k < 9; k++) kc[k] = 0;
      repeat (3) @(negedge clk);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_s_ready", s_ready, 1);
      rstn = 1'b1;

      // 1: bypass ramp, latency and single frame_done
      mode = 2'b00;
      for (int i = 0; i < 6; i++) send_pixel(8'(i));
      chk("busy_mid", busy, 1);
      for (int i = 6; i < 16; i++) send_pixel(8'(i));
      drain();
      chk("latency", first_val - first_acc, 2);
      chk("fd_count", n_fd, 1);
      chk("busy_end", busy, 0);

      // 2: invert and threshold
      mode = 2'b01;
      send_frame(1, 8'h3C);
      mode = 2'b11; thresh = 8'h80;
      send_frame(2, 0);
      drain();

      // 3: conv with centre 8 on the ramp
      mode = 2'b10;
      centre_only(8);
      n_fd = 0;
      send_frame(0, 0);
      drain();
      chk("fd_count_conv", n_fd, 1);

      // 4: saturation cases on constant 200
      centre_only(16);
      send_frame(1, 200);
      centre_only(-1);
      send_frame(1, 200);
      for (int k = 0; k < 9; k++) kc[k] = -1;
      kc[4] = 8;
      set_kernel();
      send_frame(1, 200);
      drain();

      // 5: backpressure mid-frame
      mode = 2'b00;
      for (int i = 0; i < 6; i++) send_pixel(8'(i));
      hold = 5; stall_chk = 1;
      for (int i = 6; i < 16; i++) send_pixel(8'(i));
      stall_chk = 0;
      drain();

      // 6a: mode change mid-frame takes effect only at next frame
      mode = 2'b00;
      for (int i = 0; i < 7; i++) send_pixel(8'(i));
      mode = 2'b01;
      for (int i = 7; i < 16; i++) send_pixel(8'(i));
      send_frame(0, 0);
      drain();

      // 6b: reset mid-frame
      mode = 2'b00;
      for (int i = 0; i < 6; i++) send_pixel(8'(i + 100));
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("rst_mid_m_valid", m_valid, 0);
      chk("rst_mid_busy", busy, 0);
      sb.delete();
      mrow = 0; mcol = 0;
      s_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      send_frame(0, 0);
      drain();

      // 7: rounding behaviour, centre 1 on constant 4
      mode = 2'b10;
      centre_only(1);
      send_frame(1, 4);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
